// File: rtl/gdp_if.sv
// Signal bundle between the pipeline tail, the deparser and the output port.
interface gdp_if;
  logic [255:0]  in_gdp_md;
  logic          in_gdp_md_wr;
  logic          out_gdp_md_alf;
  logic [1023:0] in_gdp_phv;
  logic          in_gdp_phv_wr;
  logic          out_gdp_phv_alf;
  logic [133:0]  in_gdp_data;
  logic          in_gdp_data_wr;
  logic          in_gdp_valid_wr;
  logic          in_gdp_valid;
  logic          out_gdp_data_alf;
  logic [133:0]  pktout_data;
  logic          pktout_data_wr;
  logic          pktout_valid_wr;
  logic          pktout_valid;
  logic          pktout_ready;

  modport master (
    output in_gdp_md, in_gdp_md_wr, in_gdp_phv, in_gdp_phv_wr,
           in_gdp_data, in_gdp_data_wr, in_gdp_valid_wr, in_gdp_valid,
           pktout_ready,
    input  out_gdp_md_alf, out_gdp_phv_alf, out_gdp_data_alf,
           pktout_data, pktout_data_wr, pktout_valid_wr, pktout_valid
  );

  modport slave (
    input  in_gdp_md, in_gdp_md_wr, in_gdp_phv, in_gdp_phv_wr,
           in_gdp_data, in_gdp_data_wr, in_gdp_valid_wr, in_gdp_valid,
           pktout_ready,
    output out_gdp_md_alf, out_gdp_phv_alf, out_gdp_data_alf,
           pktout_data, pktout_data_wr, pktout_valid_wr, pktout_valid
  );
endinterface

// File: rtl/gdp.sv
// Generic deparser: splices MD into words 0-1 and PHV into words 2-9 of the
// cached packet and streams the rebuilt packet out; dropped packets are flushed.
module gdp_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          drop
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Show-ahead read; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!count[AW] || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module gdp #(
  parameter int DATA_AW      = 8,
  parameter int META_AW      = 2,
  parameter int DATA_ALF_GAP = 32,
  parameter int META_ALF_GAP = 1
) (
  input logic  clk,
  input logic  rst,
  gdp_if.slave bus
);
  localparam int DATA_DEPTH = 1 << DATA_AW;
  localparam int META_DEPTH = 1 << META_AW;
  localparam int PKT_W      = DATA_AW + 1;

  typedef enum logic [1:0] {IDLE, EMIT, DROP} state_t;

  state_t              state, state_n;
  logic [133:0]        word_p0;
  logic [DATA_AW:0]    data_count;
  logic [META_AW:0]    md_count, phv_count, keep_count;
  logic [255:0]        md_head, md_q;
  logic [1023:0]       phv_head, phv_q;
  logic [0:0]          keep_head;
  logic                data_drop, md_drop, phv_drop, keep_drop;
  logic                pop_data, pop_meta, load_out, tail_pop, is_tail;
  logic [PKT_W-1:0]    pkt_cnt;
  logic [7:0]          w;
  logic                ovf;
  logic                unused_ovf;
  logic [133:0]        out_data_p1;
  logic                out_wr_p1, out_eop_p1;

  gdp_fifo #(.W(134), .AW(DATA_AW)) u_data (
    .clk(clk), .rst(rst), .push(bus.in_gdp_data_wr), .wdata(bus.in_gdp_data),
    .pop(pop_data), .rdata(word_p0), .count(data_count), .drop(data_drop));

  gdp_fifo #(.W(256), .AW(META_AW)) u_md (
    .clk(clk), .rst(rst), .push(bus.in_gdp_md_wr), .wdata(bus.in_gdp_md),
    .pop(pop_meta), .rdata(md_head), .count(md_count), .drop(md_drop));

  gdp_fifo #(.W(1024), .AW(META_AW)) u_phv (
    .clk(clk), .rst(rst), .push(bus.in_gdp_phv_wr), .wdata(bus.in_gdp_phv),
    .pop(pop_meta), .rdata(phv_head), .count(phv_count), .drop(phv_drop));

  gdp_fifo #(.W(1), .AW(META_AW)) u_keep (
    .clk(clk), .rst(rst), .push(bus.in_gdp_valid_wr), .wdata(bus.in_gdp_valid),
    .pop(pop_meta), .rdata(keep_head), .count(keep_count), .drop(keep_drop));

  assign bus.out_gdp_data_alf = (DATA_DEPTH - int'(data_count)) < DATA_ALF_GAP;
  assign bus.out_gdp_md_alf   = (META_DEPTH - int'(md_count))  <= META_ALF_GAP;
  assign bus.out_gdp_phv_alf  = (META_DEPTH - int'(phv_count)) <= META_ALF_GAP;

  // ovf is a debug-visible sticky flag with no port of its own.
  assign unused_ovf = ovf;
  assign is_tail    = (word_p0[133:132] == 2'b10);

  function automatic logic [127:0] splice(input logic [7:0] idx,
                                          input logic [1:0][127:0] md,
                                          input logic [7:0][127:0] phv,
                                          input logic [127:0] raw);
    logic [2:0] seg;
    seg = 3'(idx - 8'd2);
    if (idx < 8'd2)  return md[idx[0]];
    if (idx < 8'd10) return phv[3'd7 - seg];
    return raw;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pop_data = 1'b0;
    pop_meta = 1'b0;
    load_out = 1'b0;
    tail_pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (pkt_cnt != '0 && md_count != '0 && phv_count != '0 && keep_count != '0) begin
          pop_meta = 1'b1;
          state_n  = keep_head[0] ? EMIT : DROP;
        end
      end
      EMIT: begin
        if (bus.pktout_ready && data_count != '0) begin
          pop_data = 1'b1;
          load_out = 1'b1;
          if (is_tail) begin
            tail_pop = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      DROP: begin
        if (data_count != '0) begin
          pop_data = 1'b1;
          if (is_tail) begin
            tail_pop = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pop_meta) begin
      md_q  <= md_head;
      phv_q <= phv_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
      w       <= '0;
      ovf     <= 1'b0;
    end else begin
      if (data_drop || md_drop || phv_drop || keep_drop) ovf <= 1'b1;
      case ({bus.in_gdp_valid_wr, tail_pop})
        2'b10:   pkt_cnt <= pkt_cnt + PKT_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PKT_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (pop_meta)                      w <= '0;
      else if (load_out && w != 8'd255) w <= w + 8'd1;
    end
  end

  // ---- output stage p1: one registered word per popped cached word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_p1 <= '0;
      out_wr_p1   <= 1'b0;
      out_eop_p1  <= 1'b0;
    end else begin
      out_wr_p1  <= load_out;
      out_eop_p1 <= load_out && is_tail;
      if (load_out)
        out_data_p1 <= {word_p0[133:128], splice(w, md_q, phv_q, word_p0[127:0])};
    end
  end

  assign bus.pktout_data     = out_data_p1;
  assign bus.pktout_data_wr  = out_wr_p1;
  assign bus.pktout_valid_wr = out_eop_p1;
  assign bus.pktout_valid    = out_eop_p1;
endmodule

// File: tb/tb_gdp.sv
// Randomized and directed bench for the deparser with a queue-based reference model.
`timescale 1ns/1ps
module tb_gdp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gdp_if bus();
  gdp dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [134:0] exp_q[$];
  logic [133:0] got_q[$];
  logic [134:0] e;
  bit rand_ready = 1'b0;
  bit force_ready = 1'b1;
  bit rnd_bit = 1'b1;

  assign bus.pktout_ready = rand_ready ? rnd_bit : force_ready;
  always @(negedge clk) rnd_bit = (($urandom % 4) != 0);

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare process: every output word against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pktout_data_wr) begin
        got_q.push_back(bus.pktout_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h required=none", bus.pktout_data);
        end else begin
          e = exp_q.pop_front();
          check("word", bus.pktout_data, e[133:0]);
          check("eop", 134'({bus.pktout_valid_wr, bus.pktout_valid}), 134'({e[134], e[134]}));
        end
      end else begin
        check("strobe_without_word", 134'({bus.pktout_valid_wr, bus.pktout_valid}), '0);
      end
    end
  end

  task automatic send_pkt(input int len, input bit keep, input logic [255:0] md,
                          input logic [1023:0] phv, input logic [31:0] tag);
    logic [1:0]    ty;
    logic [3:0]    info;
    logic [127:0]  pay, mp;
    logic [1023:0] sh;
    int c;
    c = 0;
    while ((bus.out_gdp_md_alf || bus.out_gdp_phv_alf || bus.out_gdp_data_alf) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 2000) begin
      checks++;
      failures++;
      $display("FAIL upstream_alf_timeout actual=stuck required=free");
    end
    bus.in_gdp_md     = md;
    bus.in_gdp_phv    = phv;
    bus.in_gdp_md_wr  = 1'b1;
    bus.in_gdp_phv_wr = 1'b1;
    @(posedge clk); #1;
    bus.in_gdp_md_wr  = 1'b0;
    bus.in_gdp_phv_wr = 1'b0;
    for (int i = 0; i < len; i++) begin
      ty   = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
      info = 4'(tag + 32'(i));
      pay  = {tag, 32'(i), 64'h0123456789ABCDEF};
      if (i < 2) begin
        sh = {768'b0, md} >> (128 * i);
        mp = sh[127:0];
      end else if (i < 10) begin
        sh = phv >> (128 * (9 - i));
        mp = sh[127:0];
      end else begin
        mp = pay;
      end
      if (keep) exp_q.push_back({1'(i == len - 1), ty, info, mp});
      bus.in_gdp_data     = {ty, info, pay};
      bus.in_gdp_data_wr  = 1'b1;
      bus.in_gdp_valid_wr = (i == len - 1);
      bus.in_gdp_valid    = keep;
      @(posedge clk); #1;
    end
    bus.in_gdp_data_wr  = 1'b0;
    bus.in_gdp_valid_wr = 1'b0;
    bus.in_gdp_valid    = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check(name, 134'(exp_q.size()), '0);
    @(posedge clk); #1;
  endtask

  task automatic rand_meta(output logic [255:0] md, output logic [1023:0] phv);
    md = '0;
    phv = '0;
    for (int k = 0; k < 8; k++)  md  = {md[223:0], 32'($urandom)};
    for (int k = 0; k < 32; k++) phv = {phv[991:0], 32'($urandom)};
  endtask

  logic [255:0]  md1, md3, mdr;
  logic [1023:0] phv_a, phv_b, phvr;
  int n;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_gdp_md = '0;     bus.in_gdp_md_wr = 1'b0;
    bus.in_gdp_phv = '0;    bus.in_gdp_phv_wr = 1'b0;
    bus.in_gdp_data = '0;   bus.in_gdp_data_wr = 1'b0;
    bus.in_gdp_valid_wr = 1'b0; bus.in_gdp_valid = 1'b0;
    md1   = {128'h11112222333344445555666677778888, 128'h1000000000000000000000000000000F};
    md3   = {128'h33333333333333333333333333333333, 128'h3000000000000000000000000000000C};
    phv_a = {{16{8'hA0}}, {16{8'hA1}}, {16{8'hA2}}, {16{8'hA3}},
             {16{8'hA4}}, {16{8'hA5}}, {16{8'hA6}}, {16{8'hA7}}};
    phv_b = {{16{8'hB0}}, {16{8'hB1}}, 768'b0};
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_data_wr", 134'(bus.pktout_data_wr), '0);
    check("reset_valid", 134'({bus.pktout_valid_wr, bus.pktout_valid}), '0);
    check("reset_data", bus.pktout_data, '0);
    check("reset_alf", 134'({bus.out_gdp_md_alf, bus.out_gdp_phv_alf, bus.out_gdp_data_alf}), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 12-word keep packet with start latency
    got_q.delete();
    send_pkt(12, 1'b1, md1, phv_a, 32'd1);
    @(negedge clk); check("latency_c1", 134'(bus.pktout_data_wr), '0);
    @(negedge clk); check("latency_c2", 134'(bus.pktout_data_wr), '0);
    @(negedge clk); check("latency_c3", 134'(bus.pktout_data_wr), 134'(1));
    drain("drain_pkt12");
    check("pkt12_len", 134'(got_q.size()), 134'(12));
    if (got_q.size() == 12) begin
      check("pkt12_w0", got_q[0], {2'b01, 4'h1, 128'h1000000000000000000000000000000F});
      check("pkt12_w1", got_q[1], {2'b11, 4'h2, 128'h11112222333344445555666677778888});
      check("pkt12_w2", got_q[2], {2'b11, 4'h3, 128'hA0A0A0A0A0A0A0A0A0A0A0A0A0A0A0A0});
      check("pkt12_w9", got_q[9], {2'b11, 4'hA, 128'hA7A7A7A7A7A7A7A7A7A7A7A7A7A7A7A7});
      check("pkt12_w10", got_q[10], {2'b11, 4'hB, 128'h000000010000000A0123456789ABCDEF});
      check("pkt12_w11", got_q[11], {2'b10, 4'hC, 128'h000000010000000B0123456789ABCDEF});
    end

    // 4-word packet uses only the top PHV segments
    got_q.delete();
    send_pkt(4, 1'b1, md1, phv_b, 32'd2);
    drain("drain_pkt4");
    check("pkt4_len", 134'(got_q.size()), 134'(4));
    if (got_q.size() == 4) begin
      check("pkt4_w2", got_q[2], {2'b11, 4'h4, 128'hB0B0B0B0B0B0B0B0B0B0B0B0B0B0B0B0});
      check("pkt4_w3", got_q[3], {2'b10, 4'h5, 128'hB1B1B1B1B1B1B1B1B1B1B1B1B1B1B1B1});
    end

    // dropped packet followed by a kept one
    got_q.delete();
    send_pkt(5, 1'b0, md1, phv_a, 32'd3);
    send_pkt(12, 1'b1, md3, phv_b, 32'd4);
    drain("drain_drop");
    check("drop_len", 134'(got_q.size()), 134'(12));
    if (got_q.size() == 12)
      check("drop_w0", got_q[0], {2'b01, 4'h4, 128'h3000000000000000000000000000000C});
    check("meta_consumed", 134'({dut.md_count, dut.phv_count}), '0);

    // back-pressure for 3 cycles at w=5
    got_q.delete();
    send_pkt(12, 1'b1, md3, phv_a, 32'd5);
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(negedge clk);
      if (bus.pktout_data_wr) n++;
    end
    check("stall_reach_w5", 134'(n), 134'(5));
    force_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_gap", 134'(bus.pktout_data_wr), '0);
    end
    force_ready = 1'b1;
    @(negedge clk);
    check("stall_resume", 134'(bus.pktout_data_wr), 134'(1));
    drain("drain_stall");
    check("stall_len", 134'(got_q.size()), 134'(12));

    // randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      rand_meta(mdr, phvr);
      send_pkt(int'($urandom_range(24, 2)), ($urandom % 4) != 0, mdr, phvr, $urandom);
    end
    drain("drain_random");
    rand_ready = 1'b0;

    // reset in the middle of a 20-word packet
    got_q.delete();
    send_pkt(20, 1'b1, md1, phv_a, 32'd6);
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      if (bus.pktout_data_wr) n++;
    end
    check("rst_reach_w6", 134'(n), 134'(6));
    #1 rst = 1'b1;
    #1;
    check("rst_mid_wr", 134'({bus.pktout_data_wr, bus.pktout_valid_wr, bus.pktout_valid}), '0);
    check("rst_mid_data", bus.pktout_data, '0);
    check("rst_mid_fifo", 134'({dut.data_count, dut.pkt_cnt, dut.md_count}), '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    send_pkt(12, 1'b1, md3, phv_a, 32'd7);
    drain("drain_after_rst");
    check("after_rst_len", 134'(got_q.size()), 134'(12));

    // MD almost-full and overflow
    check("ovf_clear", 134'(dut.ovf), '0);
    for (int k = 0; k < 5; k++) begin
      bus.in_gdp_md = md1;
      bus.in_gdp_md_wr = 1'b1;
      @(posedge clk); #1;
      bus.in_gdp_md_wr = 1'b0;
      if (k == 1) check("md_alf_2", 134'(bus.out_gdp_md_alf), '0);
      if (k == 2) check("md_alf_3", 134'(bus.out_gdp_md_alf), 134'(1));
      if (k == 3) check("md_alf_4", 134'({bus.out_gdp_md_alf, dut.ovf}), 134'(2'b10));
      if (k == 4) check("md_ovf_5", 134'({bus.out_gdp_md_alf, dut.ovf, dut.md_count}), 134'({2'b11, 3'd4}));
    end
    check("phv_alf_idle", 134'(bus.out_gdp_phv_alf), '0);

    // data almost-full threshold
    bus.in_gdp_data = {2'b11, 4'h0, 128'h0};
    bus.in_gdp_data_wr = 1'b1;
    repeat (224) @(posedge clk);
    #1;
    bus.in_gdp_data_wr = 1'b0;
    check("data_alf_224", 134'(bus.out_gdp_data_alf), '0);
    bus.in_gdp_data_wr = 1'b1;
    @(posedge clk); #1;
    bus.in_gdp_data_wr = 1'b0;
    check("data_alf_225", 134'(bus.out_gdp_data_alf), 134'(1));
    rst = 1'b1;
    #2;
    check("rst_clears_alf", 134'({bus.out_gdp_md_alf, bus.out_gdp_data_alf, dut.ovf}), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
